// File: rtl/bola_nave.sv
// bola_nave: player-ship projectile that climbs from the ship nose and hit-tests one enemy box.
// Optional TIRO_AUTO_EN: level-sensitive fire button (autofire while held).
module bola_nave #(
    parameter int CLK_DIV   = 50000,
    parameter int STEP      = 2,
    parameter int NAVE_W    = 45,
    parameter int INIM_W    = 40,
    parameter int INIM_H    = 30,
    parameter int COOLDOWN  = 100,
    parameter int OFFSCREEN = 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       disparo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] x_inim,
    input  logic [9:0] y_inim,
    input  logic       inimigo_vivo,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       ativa,
    output logic       acertou,
    output logic [7:0] acertos
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int DW = $clog2(COOLDOWN + 1);
    localparam logic [9:0] PARK = 10'(OFFSCREEN);

    typedef enum logic {IDLE, VOO} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cd_q, cd_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic          pedido_q, pedido_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          acertou_q, acertou_d;
    logic [7:0]    acertos_q, acertos_d;
    logic          tick, fire, hit;

    always_comb begin
        sync_d    = {sync_q[0], disparo};
        prev_d    = sync_q[1];
        state_d   = state_q;
        cd_d      = cd_q;
        pedido_d  = pedido_q;
        x_d       = x_q;
        y_d       = y_q;
        acertou_d = 1'b0;
        acertos_d = acertos_q;
        tick      = !pausa && cnt_q == CW'(CLK_DIV - 1);
        cnt_d     = pausa ? cnt_q : (tick ? '0 : cnt_q + CW'(1));
`ifdef TIRO_AUTO_EN
        fire      = sync_q[1];
`else
        fire      = sync_q[1] && !prev_q;
`endif
        // Sums widened to 11 bits so a box near the right/bottom edge never wraps
        hit       = inimigo_vivo
                    && x_q >= x_inim && {1'b0, x_q} <= {1'b0, x_inim} + 11'(INIM_W)
                    && y_q >= y_inim && {1'b0, y_q} <= {1'b0, y_inim} + 11'(INIM_H);
        if (fire && state_q == IDLE && cd_q == '0 && !pausa)
            pedido_d = 1'b1;
        if (tick) begin
            if (state_q == IDLE) begin
                if (cd_q != '0) begin
                    cd_d = cd_q - DW'(1);
                end else if (pedido_q) begin
                    pedido_d = 1'b0;
                    if (y_nave != '0) begin
                        x_d     = x_nave + 10'(NAVE_W / 2);
                        y_d     = y_nave - 10'(1);
                        state_d = VOO;
                    end
                end
            end else if (hit || y_q < 10'(STEP)) begin
                acertou_d = hit;
                acertos_d = hit ? acertos_q + 8'd1 : acertos_q;
                x_d       = PARK;
                y_d       = PARK;
                cd_d      = DW'(COOLDOWN);
                state_d   = IDLE;
            end else begin
                y_d = y_q - 10'(STEP);
            end
        end
        if (reiniciarJogo) begin
            state_d   = IDLE;
            cnt_d     = '0;
            cd_d      = '0;
            pedido_d  = 1'b0;
            x_d       = PARK;
            y_d       = PARK;
            acertou_d = 1'b0;
            acertos_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cd_q      <= '0;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pedido_q  <= 1'b0;
            x_q       <= PARK;
            y_q       <= PARK;
            acertou_q <= 1'b0;
            acertos_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cd_q      <= cd_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pedido_q  <= pedido_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acertou_q <= acertou_d;
            acertos_q <= acertos_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign ativa   = state_q == VOO;
    assign acertou = acertou_q;
    assign acertos = acertos_q;
endmodule

// File: tb/tb_bola_nave.sv
// tb_bola_nave: directed scenario tests for bola_nave with CLK_DIV=4, STEP=2, COOLDOWN=3.
module tb_bola_nave;
    logic       clk = 1'b0;
    logic       rst_n, pausa, reiniciar, disparo, vivo;
    logic [9:0] x_nave, y_nave, x_inim, y_inim, x, y;
    logic       ativa, acertou;
    logic [7:0] acertos;
    int         passed = 0, total = 0;

    bola_nave #(.CLK_DIV(4), .STEP(2), .COOLDOWN(3)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .pausa(pausa), .reiniciarJogo(reiniciar),
        .disparo(disparo), .x_nave(x_nave), .y_nave(y_nave), .x_inim(x_inim),
        .y_inim(y_inim), .inimigo_vivo(vivo), .x(x), .y(y), .ativa(ativa),
        .acertou(acertou), .acertos(acertos)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk);
        disparo = 1'b1;
        cycles(3);
        disparo = 1'b0;
    endtask

    task automatic wait_change(input int n, output bit ok);
        logic [9:0] y0;
        y0 = y;
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (y !== y0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (x !== 10'd1000 || y !== 10'd1000) $display("FAIL reset_pos x=%0d y=%0d want 1000/1000", x, y); else passed++;
        total++; if (ativa !== 1'b0 || acertou !== 1'b0) $display("FAIL reset_flags ativa=%b acertou=%b want 0/0", ativa, acertou); else passed++;
        total++; if (acertos !== 8'd0) $display("FAIL reset_acertos got=%0d want 0", acertos); else passed++;
        cycles(20);
        total++; if (y !== 10'd1000 || ativa !== 1'b0) $display("FAIL reset_idle y=%0d ativa=%b want 1000/0", y, ativa); else passed++;
    endtask

    task automatic test_launch_hit();
        bit ok, seen;
        x_nave = 10'd300; y_nave = 10'd400; x_inim = 10'd310; y_inim = 10'd300; vivo = 1'b1;
        press();
        wait_change(20, ok);
        total++; if (!ok || x !== 10'd322 || y !== 10'd399 || ativa !== 1'b1)
            $display("FAIL launch ok=%b x=%0d y=%0d ativa=%b want 322/399/1", ok, x, y, ativa); else passed++;
        for (int k = 1; k <= 35; k++) begin
            wait_change(10, ok);
            total++; if (!ok || y !== 10'(399 - 2 * k) || acertou !== 1'b0)
                $display("FAIL climb%0d ok=%b y=%0d acertou=%b want %0d/0", k, ok, y, acertou, 399 - 2 * k); else passed++;
        end
        total++; if (x !== 10'd322) $display("FAIL x_held got=%0d want 322", x); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = acertou;
        end
        total++; if (!seen) $display("FAIL hit_pulse got=0 want 1"); else passed++;
        total++; if (acertos !== 8'd1 || x !== 10'd1000 || y !== 10'd1000 || ativa !== 1'b0)
            $display("FAIL hit_state acertos=%0d x=%0d y=%0d ativa=%b want 1/1000/1000/0", acertos, x, y, ativa); else passed++;
        @(negedge clk);
        total++; if (acertou !== 1'b0) $display("FAIL hit_width acertou=%b want 0", acertou); else passed++;
    endtask

    task automatic test_top_exit();
        bit ok;
        vivo = 1'b0; x_nave = 10'd100; y_nave = 10'd10;
        cycles(20);
        press();
        wait_change(20, ok);
        total++; if (!ok || y !== 10'd9 || x !== 10'd122) $display("FAIL top_launch ok=%b x=%0d y=%0d want 122/9", ok, x, y); else passed++;
        for (int k = 1; k <= 4; k++) begin
            wait_change(10, ok);
            total++; if (!ok || y !== 10'(9 - 2 * k)) $display("FAIL top_step%0d ok=%b y=%0d want %0d", k, ok, y, 9 - 2 * k); else passed++;
        end
        wait_change(10, ok);
        total++; if (!ok || y !== 10'd1000 || x !== 10'd1000 || ativa !== 1'b0)
            $display("FAIL top_park ok=%b x=%0d y=%0d ativa=%b want 1000/1000/0", ok, x, y, ativa); else passed++;
        press();
        cycles(40);
        total++; if (y !== 10'd1000 || ativa !== 1'b0) $display("FAIL cooldown_drop y=%0d ativa=%b want 1000/0", y, ativa); else passed++;
    endtask

    task automatic test_pause_restart();
        bit ok, pulse;
        logic [9:0] rec;
        y_nave = 10'd400; vivo = 1'b0;
        press();
        wait_change(20, ok);
        wait_change(10, ok);
        wait_change(10, ok);
        total++; if (!ok || y !== 10'd395) $display("FAIL pause_pre ok=%b y=%0d want 395", ok, y); else passed++;
        pausa = 1'b1;
        rec = y;
        press();
        cycles(36);
        total++; if (y !== rec || ativa !== 1'b1) $display("FAIL pause_hold y=%0d ativa=%b want %0d/1", y, ativa, rec); else passed++;
        pausa = 1'b0;
        wait_change(10, ok);
        total++; if (!ok || y !== rec - 10'd2) $display("FAIL pause_resume ok=%b y=%0d want %0d", ok, y, rec - 10'd2); else passed++;
        total++; if (acertos !== 8'd1) $display("FAIL pre_restart acertos=%0d want 1", acertos); else passed++;
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        total++; if (x !== 10'd1000 || y !== 10'd1000 || ativa !== 1'b0 || acertos !== 8'd0)
            $display("FAIL restart x=%0d y=%0d ativa=%b acertos=%0d want 1000/1000/0/0", x, y, ativa, acertos); else passed++;
        pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulse |= acertou | ativa;
        end
        total++; if (pulse) $display("FAIL restart_quiet acertou_or_ativa=1 want 0"); else passed++;
    endtask

    task automatic test_pause_idle();
        pausa = 1'b1;
        press();
        cycles(20);
        pausa = 1'b0;
        cycles(30);
        total++; if (y !== 10'd1000 || ativa !== 1'b0) $display("FAIL pause_idle_drop y=%0d ativa=%b want 1000/0", y, ativa); else passed++;
    endtask

    task automatic test_y_zero();
        y_nave = 10'd0;
        press();
        cycles(30);
        total++; if (y !== 10'd1000 || ativa !== 1'b0) $display("FAIL y_zero y=%0d ativa=%b want 1000/0", y, ativa); else passed++;
    endtask

    task automatic test_hold_one_shot();
        bit ok, again;
        y_nave = 10'd10; x_nave = 10'd0;
        @(negedge clk);
        disparo = 1'b1;
        wait_change(20, ok);
        total++; if (!ok || y !== 10'd9 || x !== 10'd22) $display("FAIL hold_launch ok=%b x=%0d y=%0d want 22/9", ok, x, y); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (y === 10'd1000);
        end
        total++; if (!ok) $display("FAIL hold_park y=%0d want 1000", y); else passed++;
        again = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            again |= ativa;
        end
        total++; if (again) $display("FAIL hold_single relaunch=1 want 0"); else passed++;
        disparo = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pausa = 1'b0; reiniciar = 1'b0; disparo = 1'b0; vivo = 1'b0;
        x_nave = '0; y_nave = '0; x_inim = '0; y_inim = '0;
        cycles(3);
        rst_n = 1'b1;
        test_reset();
        test_launch_hit();
        test_top_exit();
        test_pause_restart();
        test_pause_idle();
        test_y_zero();
        test_hold_one_shot();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
